// File: rtl/ascon_permutation_core.sv
// Ascon-p[rnd] permutation engine: holds the 320-bit state and applies one
// round (constant addition, bit-sliced S-box layer, linear diffusion) per
// clock. Defining ASCON_PERM_UNROLL2_EN cascades two round datapaths so that
// RUN retires two rounds per cycle. A trailing odd round uses only the first one.

package ascon_pkg;
    localparam int WORD_WIDTH = 64;
    typedef logic [WORD_WIDTH-1:0] ascon_word_t;
    typedef struct packed {
        ascon_word_t s0;
        ascon_word_t s1;
        ascon_word_t s2;
        ascon_word_t s3;
        ascon_word_t s4;
    } ascon_state_t;
endpackage

// Bit-sliced Ascon substitution layer: bit j of S0..S4 is one 5-bit S-box
// lane with S0 as the most significant input bit.
module ascon_sbox_layer
    import ascon_pkg::*;
(
    input  ascon_state_t state_i,
    output ascon_state_t state_o
);
    ascon_word_t a0, a1, a2, a3, a4;
    ascon_word_t b0, b1, b2, b3, b4;

    assign a0 = state_i.s0 ^ state_i.s4;
    assign a1 = state_i.s1;
    assign a2 = state_i.s2 ^ state_i.s1;
    assign a3 = state_i.s3;
    assign a4 = state_i.s4 ^ state_i.s3;

    assign b0 = a0 ^ (~a1 & a2);
    assign b1 = a1 ^ (~a2 & a3);
    assign b2 = a2 ^ (~a3 & a4);
    assign b3 = a3 ^ (~a4 & a0);
    assign b4 = a4 ^ (~a0 & a1);

    assign state_o.s0 = b0 ^ b4;
    assign state_o.s1 = b1 ^ b0;
    assign state_o.s2 = ~b2;
    assign state_o.s3 = b3 ^ b2;
    assign state_o.s4 = b4;
endmodule

module ascon_permutation_core
    import ascon_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  ascon_state_t state_i,
    input  logic [4:0]   rounds_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output ascon_state_t state_o,
    output logic         busy_o
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_e;

    localparam logic [7:0] ROUND_CONST [16] = '{
        8'h3c, 8'h2d, 8'h1e, 8'h0f, 8'hf0, 8'he1, 8'hd2, 8'hc3,
        8'hb4, 8'ha5, 8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b
    };

    fsm_e         fsm_q, fsm_d;
    ascon_state_t state_q, state_d;
    logic [3:0]   idx_q, idx_d;
    logic [4:0]   rnd_eff;

    ascon_state_t pc0, ps0, round0;

    function automatic ascon_state_t add_const(input ascon_state_t s, input logic [3:0] idx);
        ascon_state_t r;
        r = s;
        r.s2[7:0] = s.s2[7:0] ^ ROUND_CONST[idx];
        return r;
    endfunction

    function automatic ascon_word_t ror(input ascon_word_t x, input int n);
        return (x >> n) | (x << (WORD_WIDTH - n));
    endfunction

    function automatic ascon_state_t lin_diff(input ascon_state_t s);
        ascon_state_t r;
        r.s0 = s.s0 ^ ror(s.s0, 19) ^ ror(s.s0, 28);
        r.s1 = s.s1 ^ ror(s.s1, 61) ^ ror(s.s1, 39);
        r.s2 = s.s2 ^ ror(s.s2, 1)  ^ ror(s.s2, 6);
        r.s3 = s.s3 ^ ror(s.s3, 10) ^ ror(s.s3, 17);
        r.s4 = s.s4 ^ ror(s.s4, 7)  ^ ror(s.s4, 41);
        return r;
    endfunction

    // Round counts above 16 behave exactly like a full 16-round permutation.
    assign rnd_eff = (rounds_i > 5'd16) ? 5'd16 : rounds_i;

    assign pc0 = add_const(state_q, idx_q);
    ascon_sbox_layer u_sbox0 (.state_i(pc0), .state_o(ps0));
    assign round0 = lin_diff(ps0);

`ifdef ASCON_PERM_UNROLL2_EN
    ascon_state_t pc1, ps1, round1;
    logic [3:0]   idx_plus1;

    assign idx_plus1 = idx_q + 4'd1;
    assign pc1 = add_const(round0, idx_plus1);
    ascon_sbox_layer u_sbox1 (.state_i(pc1), .state_o(ps1));
    assign round1 = lin_diff(ps1);
`endif

    // Next-state logic: accept in IDLE, advance rounds in RUN, hold the result in DONE.
    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        idx_d   = idx_q;
        unique case (fsm_q)
            IDLE: begin
                if (in_valid_i) begin
                    state_d = state_i;
                    idx_d   = 4'(5'd16 - rnd_eff);
                    fsm_d   = (rnd_eff == 5'd0) ? DONE : RUN;
                end
            end
            RUN: begin
`ifdef ASCON_PERM_UNROLL2_EN
                if (idx_q == 4'd15) begin
                    state_d = round0;
                    idx_d   = idx_q + 4'd1;
                    fsm_d   = DONE;
                end else begin
                    state_d = round1;
                    idx_d   = idx_q + 4'd2;
                    if (idx_q == 4'd14) begin
                        fsm_d = DONE;
                    end
                end
`else
                state_d = round0;
                idx_d   = idx_q + 4'd1;
                if (idx_q == 4'd15) begin
                    fsm_d = DONE;
                end
`endif
            end
            DONE: begin
                if (out_ready_i) begin
                    fsm_d = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    // State, round index and FSM registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            idx_q   <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    assign in_ready_o  = (fsm_q == IDLE);
    assign out_valid_o = (fsm_q == DONE);
    assign busy_o      = (fsm_q == RUN);
    assign state_o     = state_q;
endmodule

// File: tb/tb_ascon_permutation_core.sv
// Self-checking bench for ascon_permutation_core: a lane-wise Ascon-p model
// built from the S-box truth table, a cycle-level expectation tracker and a
// compare process, plus directed jobs with literal expectations.
// Honours ASCON_PERM_UNROLL2_EN for the expected cycle counts.

module tb_ascon_permutation_core;
    import ascon_pkg::*;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         in_valid_i = 1'b0;
    logic         in_ready_o;
    ascon_state_t state_i = '0;
    logic [4:0]   rounds_i = 5'd0;
    logic         out_valid_o;
    logic         out_ready_i = 1'b0;
    ascon_state_t state_o;
    logic         busy_o;

    int errors = 0;
    int checks = 0;

    localparam logic [4:0] SBOX_TAB [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };
    localparam int ROT_A [5] = '{19, 61, 1, 10, 7};
    localparam int ROT_B [5] = '{28, 39, 6, 17, 41};

    ascon_permutation_core dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .state_i    (state_i),
        .rounds_i   (rounds_i),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .state_o    (state_o),
        .busy_o     (busy_o)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk_i = ~clk_i;

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic check_word(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_state(input string name, input ascon_state_t act, input ascon_state_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] round_const(input int i);
        return 8'(((19 - i) << 4) | ((i + 12) & 15));
    endfunction

    function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
        logic [63:0] y;
        for (int b = 0; b < 64; b++) y[b] = x[(b + n) % 64];
        return y;
    endfunction

    // Golden Ascon-p[rnd]: per-lane S-box table lookup and rotations by loop.
    function automatic ascon_state_t golden(input ascon_state_t s, input int rnd);
        logic [63:0] w [5];
        logic [63:0] t [5];
        logic [4:0]  v;
        logic [4:0]  o;
        ascon_state_t r;
        w[0] = s.s0; w[1] = s.s1; w[2] = s.s2; w[3] = s.s3; w[4] = s.s4;
        for (int rr = 0; rr < rnd; rr++) begin
            w[2][7:0] = w[2][7:0] ^ round_const(16 - rnd + rr);
            for (int j = 0; j < 64; j++) begin
                v = {w[0][j], w[1][j], w[2][j], w[3][j], w[4][j]};
                o = SBOX_TAB[v];
                for (int k = 0; k < 5; k++) t[k][j] = o[4 - k];
            end
            for (int k = 0; k < 5; k++) w[k] = t[k] ^ rotr(t[k], ROT_A[k]) ^ rotr(t[k], ROT_B[k]);
        end
        r.s0 = w[0]; r.s1 = w[1]; r.s2 = w[2]; r.s3 = w[3]; r.s4 = w[4];
        return r;
    endfunction

    function automatic int exp_cycles(input int eff);
`ifdef ASCON_PERM_UNROLL2_EN
        return (eff + 1) / 2;
`else
        return eff;
`endif
    endfunction

    function automatic int clamp_rounds(input int rnd);
        return (rnd > 16) ? 16 : rnd;
    endfunction

    function automatic ascon_state_t rand_state();
        ascon_state_t r;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom,
             $urandom, $urandom, $urandom, $urandom, $urandom};
        return r;
    endfunction

    // Expectation tracker: 0 = idle, 1 = running, 2 = result held.
    int           m_mode = 0;
    int           m_left = 0;
    bit           m_zero = 1'b0;
    bit           model_live = 1'b0;
    ascon_state_t m_result = '0;

    // Advance the expectation tracker on each rising edge using pre-edge inputs.
    always @(posedge clk_i) begin
        if (rst_i) begin
            m_mode = 0;
            m_left = 0;
            m_zero = 1'b1;
            model_live = 1'b1;
        end else if (m_mode == 0) begin
            if (in_valid_i) begin
                m_left   = exp_cycles(clamp_rounds(int'(rounds_i)));
                m_result = golden(state_i, clamp_rounds(int'(rounds_i)));
                m_zero   = 1'b0;
                m_mode   = (m_left == 0) ? 2 : 1;
            end
        end else if (m_mode == 1) begin
            m_left--;
            if (m_left == 0) m_mode = 2;
        end else if (out_ready_i) begin
            m_mode = 0;
        end
    end

    // Compare DUT outputs against the tracker on every falling edge.
    always @(negedge clk_i) begin
        if (model_live) begin
            check_bit("cmp in_ready", in_ready_o, m_mode == 0);
            check_bit("cmp out_valid", out_valid_o, m_mode == 2);
            check_bit("cmp busy", busy_o, m_mode == 1);
            if (m_mode == 2) check_state("cmp state_o", state_o, m_result);
            else if (m_zero && m_mode == 0) check_state("cmp reset state_o", state_o, '0);
        end
    end

    // Issue one job, measure latency and busy cycles, optionally stall and
    // pulse stray requests, then release it.
    task automatic apply_stimulus(input ascon_state_t s, input int rnd, input int hold,
                                  input bit pulse, output ascon_state_t res);
        int eff, lat, busy_cnt;
        eff = clamp_rounds(rnd);
        state_i = s; rounds_i = 5'(rnd); in_valid_i = 1'b1; out_ready_i = 1'b0;
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        lat = 0; busy_cnt = 0;
        while (!out_valid_o && lat < 200) begin
            if (busy_o) busy_cnt++;
            if (pulse) begin
                in_valid_i = lat[0]; state_i = ~s; rounds_i = 5'd2;
            end
            @(posedge clk_i); #1;
            lat++;
        end
        in_valid_i = 1'b0;
        check_int($sformatf("latency rnd=%0d", rnd), lat, exp_cycles(eff));
        check_int($sformatf("busy cycles rnd=%0d", rnd), busy_cnt, exp_cycles(eff));
        check_state($sformatf("result rnd=%0d", rnd), state_o, golden(s, eff));
        res = state_o;
        for (int h = 0; h < hold; h++) begin
            if (pulse) begin
                in_valid_i = ~h[0]; state_i = ~s; rounds_i = 5'd1;
            end
            @(posedge clk_i); #1;
            check_state("backpressure stable", state_o, res);
            check_bit("backpressure valid", out_valid_o, 1'b1);
        end
        in_valid_i = 1'b0; out_ready_i = 1'b1;
        @(posedge clk_i); #1;
        out_ready_i = 1'b0;
        check_bit("ready after release", in_ready_o, 1'b1);
    endtask

    task automatic check_output(input string tag);
        check_bit({tag, " in_ready"}, in_ready_o, 1'b1);
        check_bit({tag, " out_valid"}, out_valid_o, 1'b0);
        check_bit({tag, " busy"}, busy_o, 1'b0);
        check_state({tag, " state_o"}, state_o, '0);
    endtask

    // Hard time limit so the bench can never hang.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test sequence.
    initial begin
        ascon_state_t zero, s, res, g;
        zero = '0;

        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        check_output("reset");

        g = golden(zero, 1);
        check_word("model S1 rnd1", g.s1, 64'h0000_0000_9600_0213);
        check_word("model S3 rnd1", g.s3, 64'h12E5_8000_0000_004B);
        check_word("model S4 rnd1", g.s4, 64'h0);
        check_state("model rnd0 identity", golden(64'h1234 ^ zero, 0), 64'h1234 ^ zero);

        apply_stimulus(zero, 1, 0, 1'b0, res);
        check_word("dut S1 rnd1", res.s1, 64'h0000_0000_9600_0213);
        check_word("dut S3 rnd1", res.s3, 64'h12E5_8000_0000_004B);
        check_word("dut S4 rnd1", res.s4, 64'h0);

        apply_stimulus(rand_state(), 12, 0, 1'b1, res);
        apply_stimulus(rand_state(), 8, 10, 1'b1, res);

        s = rand_state();
        apply_stimulus(s, 0, 2, 1'b0, res);
        check_state("rnd0 passthrough", res, s);

        s = rand_state();
        apply_stimulus(s, 16, 0, 1'b0, res);
        apply_stimulus(s, 20, 0, 1'b0, res);
        check_state("rnd20 equals rnd16", res, golden(s, 16));

        apply_stimulus(rand_state(), 3, 0, 1'b0, res);
        apply_stimulus(rand_state(), 5, 0, 1'b0, res);

        s = rand_state();
        state_i = s; rounds_i = 5'd12; in_valid_i = 1'b1;
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        repeat (4) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        check_output("mid-run reset");
        rst_i = 1'b0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk_i); #1;
            check_bit("no valid after reset", out_valid_o, 1'b0);
        end

        apply_stimulus(rand_state(), 12, 0, 1'b0, res);

        repeat (2) @(posedge clk_i);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
